// File: rtl/matrix_3_3_c_writer.sv
// matrix_3_3_c_writer
// Result-side storage for the 3x3 matrix multiplier. Product elements arrive
// one at a time and are stored row-major into a 3x3 register array; full rises
// once all nine have been accepted. A registered random-access read port
// returns any element by (row, col).
//
// Optional build macro: MATRIX_C_CHECKSUM_EN adds a `checksum` output that
// accumulates the sum of every accepted element since the last reset or clear.
//
// Handshake: an element is transferred on a rising edge where in_valid and
// in_ready are both high and clear is low. in_ready does not depend on
// in_valid. While in_ready is low, in_valid and in_data are ignored.

module matrix_3_3_c_writer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [1:0]        wr_row,
    output logic [1:0]        wr_col,
    output logic              full,
    input  logic [1:0]        rd_row,
    input  logic [1:0]        rd_col,
    output logic [DATA_W-1:0] rd_data
`ifdef MATRIX_C_CHECKSUM_EN
    ,
    output logic [DATA_W+3:0] checksum
`endif
);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic              last_pos;
    logic [3:0]        wr_idx;
    logic [3:0]        rd_idx;
    logic              rd_in_range;
    logic [DATA_W-1:0] mem [9];

    // Handshake decode and row-major address arithmetic; clear overrides an accept.
    always_comb begin
        accept      = in_valid && in_ready && !clear;
        last_pos    = (wr_row == 2'd2) && (wr_col == 2'd2);
        wr_idx      = ({2'b00, wr_row} * 4'd3) + {2'b00, wr_col};
        rd_idx      = ({2'b00, rd_row} * 4'd3) + {2'b00, rd_col};
        rd_in_range = (rd_row != 2'd3) && (rd_col != 2'd3);
    end

    // Next-state logic: fill until the ninth accept, then hold until clear.
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = ST_FILL;
        end else begin
            case (state)
                ST_FILL: if (accept && last_pos) state_next = ST_FULL;
                ST_FULL: state_next = ST_FULL;
                default: state_next = ST_FILL;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FILL;
        end else begin
            state <= state_next;
        end
    end

    // Registered status flags, decoded from the state being entered so they track state exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready <= 1'b1;
            full     <= 1'b0;
        end else begin
            in_ready <= (state_next == ST_FILL);
            full     <= (state_next == ST_FULL);
        end
    end

    // Write position: row-major advance on each accept, wrapping to (0,0) after (2,2).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_row <= 2'd0;
            wr_col <= 2'd0;
        end else if (clear) begin
            wr_row <= 2'd0;
            wr_col <= 2'd0;
        end else if (accept) begin
            if (wr_col < 2'd2) begin
                wr_col <= wr_col + 2'd1;
            end else begin
                wr_col <= 2'd0;
                wr_row <= (wr_row == 2'd2) ? 2'd0 : wr_row + 2'd1;
            end
        end
    end

    // Element storage: zeroed only by reset; clear leaves old contents readable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) begin
                mem[i] <= '0;
            end
        end else if (accept) begin
            mem[wr_idx] <= in_data;
        end
    end

    // Registered read port, always enabled; same-address write shows the old value (read-before-write).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_in_range ? mem[rd_idx] : '0;
        end
    end

`ifdef MATRIX_C_CHECKSUM_EN
    // Running sum of accepted elements; four extra bits cover nine maximum-value elements.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (clear) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum + {4'b0000, in_data};
        end
    end
`endif

endmodule

// File: tb/tb_matrix_3_3_c_writer.sv
// Testbench for matrix_3_3_c_writer: directed steps, read results checked
// against an expected-value queue filled when each read address is driven.

module tb_matrix_3_3_c_writer;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [1:0]        wr_row;
    logic [1:0]        wr_col;
    logic              full;
    logic [1:0]        rd_row;
    logic [1:0]        rd_col;
    logic [DATA_W-1:0] rd_data;
`ifdef MATRIX_C_CHECKSUM_EN
    logic [DATA_W+3:0] checksum;
`endif

    int n_checks = 0;
    int n_err    = 0;
    logic [DATA_W-1:0] exp_q[$];

    matrix_3_3_c_writer #(.DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_row   (wr_row),
        .wr_col   (wr_col),
        .full     (full),
        .rd_row   (rd_row),
        .rd_col   (rd_col),
        .rd_data  (rd_data)
`ifdef MATRIX_C_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [DATA_W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic check_pos(input string tag, input logic [1:0] r, input logic [1:0] c);
        chk({tag, "_row"}, 32'(wr_row), 32'(r));
        chk({tag, "_col"}, 32'(wr_col), 32'(c));
    endtask

    task automatic check_flags(input string tag, input logic rdy, input logic fl);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(rdy));
        chk({tag, "_full"},     32'(full),     32'(fl));
    endtask

    // Drive a read address, queue the expected value, clock, then pop and compare.
    task automatic read(input logic [1:0] r, input logic [1:0] c,
                        input logic [DATA_W-1:0] exp, input string tag);
        logic [DATA_W-1:0] e;
        rd_row = r;
        rd_col = c;
        exp_q.push_back(exp);
        step();
        e = exp_q.pop_front();
        chk(tag, 32'(rd_data), 32'(e));
    endtask

    initial begin
        rst_n    = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        rd_row   = 2'd0;
        rd_col   = 2'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_flags("rst", 1'b1, 1'b0);
        check_pos("rst", 2'd0, 2'd0);
        chk("rst_rd_data", 32'(rd_data), 0);
`ifdef MATRIX_C_CHECKSUM_EN
        chk("rst_checksum", 32'(checksum), 0);
`endif
        rst_n = 1'b1;
        step();

        // Nine back-to-back accepts of 10..90
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'((i + 1) * 10);
            if (i == 8) check_flags("pre_ninth", 1'b1, 1'b0);
            step();
        end
        in_valid = 1'b0;
        check_flags("after_fill", 1'b0, 1'b1);
        check_pos("after_fill", 2'd0, 2'd0);
        read(2'd0, 2'd0, 8'd10, "rd_00_fill");
        read(2'd1, 2'd2, 8'd60, "rd_12_fill");
        read(2'd2, 2'd2, 8'd90, "rd_22_fill");

        // In FULL, valid data is ignored
        for (int i = 0; i < 3; i++) write(DATA_W'(200 + i));
        check_flags("full_hold", 1'b0, 1'b1);
        check_pos("full_hold", 2'd0, 2'd0);
        read(2'd0, 2'd0, 8'd10, "rd_00_full_ignored");
        read(2'd1, 2'd0, 8'd40, "rd_10_full_ignored");

        // Clear keeps contents; a new write overwrites
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_flags("after_clear", 1'b1, 1'b0);
        check_pos("after_clear", 2'd0, 2'd0);
        read(2'd0, 2'd0, 8'd10, "rd_00_after_clear");
        write(8'd33);
        read(2'd0, 2'd0, 8'd33, "rd_00_rewrite");
        check_pos("after_33", 2'd0, 2'd1);

        // Valid gaps: only 5 and 6 land
        clear = 1'b1;
        step();
        clear = 1'b0;
        in_valid = 1'b1; in_data = 8'd5;  step();
        in_valid = 1'b0; in_data = 8'd99; step();
        in_valid = 1'b1; in_data = 8'd6;  step();
        in_valid = 1'b0; in_data = 8'd99; step();
        check_pos("gaps", 2'd0, 2'd2);
        read(2'd0, 2'd0, 8'd5,  "rd_00_gaps");
        read(2'd0, 2'd1, 8'd6,  "rd_01_gaps");
        read(2'd0, 2'd2, 8'd30, "rd_02_gaps");

        // Clear wins over a simultaneous accept at (1,1)
        write(8'd7);
        write(8'd8);
        check_pos("pre_clear_accept", 2'd1, 2'd1);
        in_valid = 1'b1;
        in_data  = 8'd77;
        clear    = 1'b1;
        step();
        in_valid = 1'b0;
        clear    = 1'b0;
        check_pos("clear_accept", 2'd0, 2'd0);
        check_flags("clear_accept", 1'b1, 1'b0);
        read(2'd1, 2'd1, 8'd50, "rd_11_dropped");

        // Read-before-write at (2,1)
        for (int i = 0; i < 7; i++) write(DATA_W'(100 + i));
        check_pos("pre_rbw", 2'd2, 2'd1);
        in_valid = 1'b1;
        in_data  = 8'd147;
        read(2'd2, 2'd1, 8'd80, "rd_21_rbw_old");
        in_valid = 1'b0;
        read(2'd2, 2'd1, 8'd147, "rd_21_rbw_new");
        read(2'd1, 2'd0, 8'd103, "rd_10_refill");
        read(2'd3, 2'd0, 8'd0,   "rd_30_oor");
        read(2'd0, 2'd3, 8'd0,   "rd_03_oor");
        check_pos("post_rbw", 2'd2, 2'd2);

        // Writes 1..9 and checksum
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 1; i <= 9; i++) write(DATA_W'(i));
        check_flags("fill_1_9", 1'b0, 1'b1);
        read(2'd2, 2'd2, 8'd9, "rd_22_1_9");
`ifdef MATRIX_C_CHECKSUM_EN
        chk("checksum_45", 32'(checksum), 45);
        write(8'd250);
        chk("checksum_full_hold", 32'(checksum), 45);
`endif
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_flags("clear2", 1'b1, 1'b0);
`ifdef MATRIX_C_CHECKSUM_EN
        chk("checksum_clear", 32'(checksum), 0);
`endif

        // Asynchronous reset mid-fill after four writes
        for (int i = 1; i <= 4; i++) write(DATA_W'(i));
        check_pos("mid_fill", 2'd1, 2'd1);
        read(2'd0, 2'd0, 8'd1, "rd_00_mid_fill");
`ifdef MATRIX_C_CHECKSUM_EN
        chk("checksum_10", 32'(checksum), 10);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        check_flags("async_rst", 1'b1, 1'b0);
        check_pos("async_rst", 2'd0, 2'd0);
        chk("async_rst_rd_data", 32'(rd_data), 0);
`ifdef MATRIX_C_CHECKSUM_EN
        chk("async_rst_checksum", 32'(checksum), 0);
`endif
        step();
        rst_n = 1'b1;
        read(2'd0, 2'd0, 8'd0, "rd_00_zeroed");
        read(2'd1, 2'd0, 8'd0, "rd_10_zeroed");
        read(2'd2, 2'd2, 8'd0, "rd_22_zeroed");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
